stdp_sweep_sequencer: RTL and testbench

Parametrised STDP weight-change sequencer between the per-input spike-count bank and the synapse weight-update logic. It queues weight-change requests from N output neurons and serves them round-robin. For each served neuron it sweeps all M input indices (0..M-1), selects each input's spike count and looks up programmable potentiation/depression deltas. The results stream out on a valid/ready interface tagged with neuron and input index.

---
 rtl/stdp_sweep_sequencer_if.sv | 27 ++
 rtl/stdp_sweep_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_stdp_sweep_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stdp_sweep_sequencer_if.sv
// stdp_sweep_sequencer_if: beat stream carrying per-input STDP deltas,
// tagged with neuron and input index, on a valid/ready handshake.
interface stdp_sweep_sequencer_if #(
  parameter int W  = 24,
  parameter int AW = 10,
  parameter int NW = 4
);
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] out_neuron;
  logic [AW-1:0] out_index;
  logic [W-1:0]  del_w_plus;
  logic [W-1:0]  del_w_minus;
  logic          out_last;

  modport master (
    output out_valid, out_neuron, out_index,
    output del_w_plus, del_w_minus, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_neuron, out_index,
    input  del_w_plus, del_w_minus, out_last,
    output out_ready
  );
endinterface

// File: rtl/stdp_sweep_sequencer.sv
// stdp_sweep_sequencer: round-robin queue of weight-change requests; each
// served neuron sweeps all M inputs through a 2-stage count->LUT pipeline.
module stdp_sweep_sequencer #(
  parameter  int M  = 784,
  parameter  int N  = 16,
  parameter  int CW = 8,
  parameter  int W  = 24,
  localparam int AW = $clog2(M),
  localparam int NW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CW*M-1:0] count,
  input  logic [N-1:0]    start_wch,
  input  logic            lut_we,
  input  logic            lut_sel,
  input  logic [CW-1:0]   lut_addr,
  input  logic [W-1:0]    lut_wdata,
  stdp_sweep_sequencer_if.master ob,
  output logic [AW-1:0]   ip_select,
  output logic [N-1:0]    pending,
  output logic            busy,
  output logic            done
);

  localparam int SW = NW + 1;
  localparam logic [AW-1:0] LAST = AW'(M - 1);
  localparam logic [NW-1:0] NTOP = NW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } st_e;

  st_e st_q, st_d;

  logic [CW-1:0] cnt_a [M];
  logic [W-1:0]  plus_lut  [2**CW];
  logic [W-1:0]  minus_lut [2**CW];

  logic [N-1:0]  pend_q, pend_d, clr;
  logic [NW-1:0] ptr_q, ptr_d;
  logic [NW-1:0] nrn_q, nrn_d;
  logic [AW-1:0] ip_q, ip_d;
  logic          done_q, done_d;

  logic          s1_v_q, s1_last_q;
  logic [CW-1:0] s1_cnt_q;
  logic [AW-1:0] s1_idx_q;
  logic [NW-1:0] s1_nrn_q;

  logic          s2_v_q, s2_last_q;
  logic [AW-1:0] s2_idx_q;
  logic [NW-1:0] s2_nrn_q;
  logic [W-1:0]  s2_p_q, s2_m_q;

  logic          stall, issue, is_last, acc_last;
  logic [NW-1:0] win;
  logic [SW-1:0] sum;

  for (genvar i = 0; i < M; i++) begin : g_cnt
    assign cnt_a[i] = count[CW*i +: CW];
  end

  assign stall    = s2_v_q & ~ob.out_ready;
  assign is_last  = (ip_q == LAST);
  assign acc_last = s2_v_q & s2_last_q & ob.out_ready;

  // Descending scan so the nearest set bit after ptr_q wins.
  always_comb begin
    win = ptr_q;
    sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + SW'(k);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      if (pend_q[sum[NW-1:0]]) win = sum[NW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (|pend_q) st_d = SWEEP;
      SWEEP:   if (!stall && is_last) st_d = DRAIN;
      DRAIN:   if (acc_last) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    ip_d   = ip_q;
    nrn_d  = nrn_q;
    ptr_d  = ptr_q;
    clr    = '0;
    issue  = 1'b0;
    done_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (|pend_q) begin
          clr[win] = 1'b1;
          nrn_d    = win;
          ptr_d    = (win == NTOP) ? '0 : win + NW'(1);
          ip_d     = '0;
        end
      end
      SWEEP: begin
        if (!stall) begin
          issue = 1'b1;
          ip_d  = is_last ? '0 : ip_q + AW'(1);
        end
      end
      DRAIN:   done_d = acc_last;
      default: ;
    endcase
  end

  // Set beats clear, so a request for the neuron being picked is re-queued.
  assign pend_d = (pend_q & ~clr) | start_wch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      ptr_q  <= '0;
      nrn_q  <= '0;
      ip_q   <= '0;
      done_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
      nrn_q  <= nrn_d;
      ip_q   <= ip_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s1_cnt_q  <= '0;
      s1_idx_q  <= '0;
      s1_nrn_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_last_q <= 1'b0;
      s2_idx_q  <= '0;
      s2_nrn_q  <= '0;
      s2_p_q    <= '0;
      s2_m_q    <= '0;
    end else if (!stall) begin
      s1_v_q <= issue;
      if (issue) begin
        s1_cnt_q  <= cnt_a[ip_q];
        s1_idx_q  <= ip_q;
        s1_nrn_q  <= nrn_q;
        s1_last_q <= is_last;
      end
      s2_v_q    <= s1_v_q;
      s2_last_q <= s1_v_q & s1_last_q;
      s2_idx_q  <= s1_idx_q;
      s2_nrn_q  <= s1_nrn_q;
      s2_p_q    <= plus_lut[s1_cnt_q];
      s2_m_q    <= minus_lut[s1_cnt_q];
    end
  end

  // Tables keep their contents across reset.
  always_ff @(posedge clk) begin
    if (lut_we && !busy) begin
      if (lut_sel) minus_lut[lut_addr] <= lut_wdata;
      else         plus_lut[lut_addr]  <= lut_wdata;
    end
  end

  assign ob.out_valid   = s2_v_q;
  assign ob.out_neuron  = s2_nrn_q;
  assign ob.out_index   = s2_idx_q;
  assign ob.del_w_plus  = s2_p_q;
  assign ob.del_w_minus = s2_m_q;
  assign ob.out_last    = s2_last_q;

  assign ip_select = ip_q;
  assign pending   = pend_q;
  assign busy      = (st_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_stdp_sweep_sequencer.sv
// tb_stdp_sweep_sequencer: directed scenarios with hand-computed beats,
// M=8 N=4, plus_lut[a]=a+100, minus_lut[a]=a+200, count[i]=i.
module tb_stdp_sweep_sequencer;
  localparam int M  = 8;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int W  = 24;
  localparam int AW = 3;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CW*M-1:0] count;
  logic [N-1:0]    start_wch = '0;
  logic            lut_we = 1'b0;
  logic            lut_sel = 1'b0;
  logic [CW-1:0]   lut_addr = '0;
  logic [W-1:0]    lut_wdata = '0;
  logic [AW-1:0]   ip_select;
  logic [N-1:0]    pending;
  logic            busy;
  logic            done;

  stdp_sweep_sequencer_if #(.W(W), .AW(AW), .NW(NW)) ob ();

  stdp_sweep_sequencer #(.M(M), .N(N), .CW(CW), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .start_wch (start_wch),
    .lut_we    (lut_we),
    .lut_sel   (lut_sel),
    .lut_addr  (lut_addr),
    .lut_wdata (lut_wdata),
    .ob        (ob.master),
    .ip_select (ip_select),
    .pending   (pending),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int done_cnt = 0;
  int bn[$], bi[$], bp[$], bm[$], bl[$], bc[$];
  int done_cyc[$], done_busy[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (ob.out_valid && ob.out_ready) begin
        bn.push_back(int'(ob.out_neuron));
        bi.push_back(int'(ob.out_index));
        bp.push_back(int'(ob.del_w_plus));
        bm.push_back(int'(ob.del_w_minus));
        bl.push_back(int'(ob.out_last));
        bc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        done_busy.push_back(int'(busy));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    bn.delete(); bi.delete(); bp.delete();
    bm.delete(); bl.delete(); bc.delete();
    done_cyc.delete(); done_busy.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input int target, input string nm);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      tick();
      n++;
    end
    if (done_cnt < target) begin
      total++;
      $display("FAIL %s timeout: done_cnt=%0d need %0d", nm, done_cnt, target);
    end
  endtask

  task automatic wait_beats(input int target, input string nm);
    int n = 0;
    while (bn.size() < target && n < 100) begin
      tick();
      n++;
    end
    if (bn.size() < target) begin
      total++;
      $display("FAIL %s timeout: beats=%0d need %0d", nm, bn.size(), target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if (ob.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        pending !== 4'b0 || ip_select !== 3'b0 || ob.out_last !== 1'b0 ||
        ob.out_index !== 3'b0 || ob.out_neuron !== 2'b0 ||
        ob.del_w_plus !== 24'b0 || ob.del_w_minus !== 24'b0)
      $display("FAIL reset_state: v=%b busy=%b done=%b pend=%b ip=%0d idx=%0d",
               ob.out_valid, busy, done, pending, ip_select, ob.out_index);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic load_luts();
    for (int a = 0; a < 16; a++) begin
      lut_we = 1'b1; lut_sel = 1'b0;
      lut_addr = CW'(a); lut_wdata = W'(a + 100);
      tick();
      lut_sel = 1'b1; lut_wdata = W'(a + 200);
      tick();
    end
    lut_we = 1'b0;
  endtask

  task automatic test_single_sweep();
    int t;
    clr_mon();
    t = cyc;
    start_wch = 4'b0100;
    tick();
    start_wch = '0;
    total++;
    if (pending !== 4'b0100 || busy !== 1'b0)
      $display("FAIL pend_set: pend=%b busy=%b want 0100 0", pending, busy);
    else passed++;
    tick();
    total++;
    if (busy !== 1'b1 || ip_select !== 3'd0 || pending !== 4'b0)
      $display("FAIL sweep_start: busy=%b ip=%0d pend=%b want 1 0 0000",
               busy, ip_select, pending);
    else passed++;
    wait_done(1, "single_done");
    total++;
    if (bn.size() !== 8) $display("FAIL single_count: got %0d want 8", bn.size());
    else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bn[i] !== 2 || bi[i] !== i || bp[i] !== 100 + i ||
          bm[i] !== 200 + i || bl[i] !== int'(i == 7))
        $display("FAIL single_beat%0d: n=%0d i=%0d p=%0d m=%0d l=%0d want 2 %0d %0d %0d %0d",
                 i, bn[i], bi[i], bp[i], bm[i], bl[i], i, 100 + i, 200 + i, int'(i == 7));
      else passed++;
    end
    total++;
    if (bc[0] !== t + 4) $display("FAIL first_beat_lat: got %0d want %0d", bc[0] - t, 4);
    else passed++;
    total++;
    if (done_cyc[0] !== bc[7] + 1 || done_busy[0] !== 0)
      $display("FAIL done_timing: gap=%0d busy=%0d want 1 0",
               done_cyc[0] - bc[7], done_busy[0]);
    else passed++;
  endtask

  task automatic test_round_robin();
    int en;
    do_reset();
    clr_mon();
    start_wch = 4'b1011;
    tick();
    start_wch = '0;
    tick();
    total++;
    if (pending !== 4'b1010) $display("FAIL rr_pending: got %b want 1010", pending);
    else passed++;
    wait_done(3, "rr_done");
    for (int k = 0; k < 20; k++) tick();
    total++;
    if (done_cnt !== 3 || pending !== 4'b0 || busy !== 1'b0)
      $display("FAIL rr_end: done=%0d pend=%b busy=%b want 3 0000 0",
               done_cnt, pending, busy);
    else passed++;
    total++;
    if (bn.size() !== 24) $display("FAIL rr_count: got %0d want 24", bn.size());
    else passed++;
    for (int i = 0; i < 24; i++) begin
      en = (i < 8) ? 0 : (i < 16) ? 1 : 3;
      total++;
      if (bn[i] !== en || bi[i] !== i % 8 || bp[i] !== 100 + i % 8)
        $display("FAIL rr_beat%0d: n=%0d i=%0d p=%0d want %0d %0d %0d",
                 i, bn[i], bi[i], bp[i], en, i % 8, 100 + i % 8);
      else passed++;
    end
    total++;
    if (bc[8] !== done_cyc[0] + 3)
      $display("FAIL back_to_back: got %0d want 3", bc[8] - done_cyc[0]);
    else passed++;
  endtask

  task automatic test_stall();
    logic [AW-1:0] h_idx, h_ip;
    logic [W-1:0]  h_p;
    clr_mon();
    start_wch = 4'b0010;
    tick();
    start_wch = '0;
    wait_beats(3, "stall_pre");
    ob.out_ready = 1'b0;
    h_idx = ob.out_index;
    h_p   = ob.del_w_plus;
    h_ip  = ip_select;
    total++;
    if (ob.out_valid !== 1'b1 || h_idx !== 3'd3 || h_p !== 24'd103)
      $display("FAIL stall_entry: v=%b idx=%0d p=%0d want 1 3 103",
               ob.out_valid, h_idx, h_p);
    else passed++;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (ob.out_valid !== 1'b1 || ob.out_index !== h_idx ||
          ob.del_w_plus !== h_p || ip_select !== h_ip || busy !== 1'b1)
        $display("FAIL stall_hold%0d: v=%b idx=%0d p=%0d ip=%0d want 1 %0d %0d %0d",
                 k, ob.out_valid, ob.out_index, ob.del_w_plus, ip_select,
                 h_idx, h_p, h_ip);
      else passed++;
    end
    ob.out_ready = 1'b1;
    wait_done(1, "stall_done");
    total++;
    if (bn.size() !== 8) $display("FAIL stall_count: got %0d want 8", bn.size());
    else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bn[i] !== 1 || bi[i] !== i || bm[i] !== 200 + i)
        $display("FAIL stall_beat%0d: n=%0d i=%0d m=%0d want 1 %0d %0d",
                 i, bn[i], bi[i], bm[i], i, 200 + i);
      else passed++;
    end
  endtask

  task automatic test_resweep();
    clr_mon();
    start_wch = 4'b0100;
    tick();
    start_wch = '0;
    wait_beats(2, "resweep_pre");
    start_wch = 4'b0100;
    tick();
    start_wch = '0;
    total++;
    if (pending !== 4'b0100 || busy !== 1'b1)
      $display("FAIL resweep_queued: pend=%b busy=%b want 0100 1", pending, busy);
    else passed++;
    wait_done(2, "resweep_done");
    total++;
    if (bn.size() !== 16) $display("FAIL resweep_count: got %0d want 16", bn.size());
    else passed++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bn[i] !== 2 || bi[i] !== i % 8 || bl[i] !== int'(i % 8 == 7))
        $display("FAIL resweep_beat%0d: n=%0d i=%0d l=%0d want 2 %0d %0d",
                 i, bn[i], bi[i], bl[i], i % 8, int'(i % 8 == 7));
      else passed++;
    end
  endtask

  task automatic test_lut_busy();
    clr_mon();
    start_wch = 4'b0001;
    tick();
    start_wch = '0;
    tick();
    tick();
    total++;
    if (busy !== 1'b1) $display("FAIL lut_busy_pre: busy=%b want 1", busy);
    else passed++;
    lut_we = 1'b1; lut_sel = 1'b0; lut_addr = 8'd3; lut_wdata = 24'hABCDEF;
    tick();
    tick();
    lut_we = 1'b0;
    wait_done(1, "lut_a_done");
    start_wch = 4'b0010;
    tick();
    start_wch = '0;
    wait_done(2, "lut_b_done");
    total++;
    if (bi[11] !== 3 || bp[11] !== 103)
      $display("FAIL lut_write_busy: idx=%0d p=%0h want 3 67", bi[11], bp[11]);
    else passed++;
    lut_we = 1'b1; lut_sel = 1'b0; lut_addr = 8'd3; lut_wdata = 24'hABCDEF;
    tick();
    lut_we = 1'b0;
    start_wch = 4'b0100;
    tick();
    start_wch = '0;
    wait_done(3, "lut_c_done");
    total++;
    if (bi[19] !== 3 || bp[19] !== 24'hABCDEF || bm[19] !== 203 || bp[18] !== 102)
      $display("FAIL lut_write_idle: idx=%0d p=%0h m=%0d p2=%0d want 3 abcdef 203 102",
               bi[19], bp[19], bm[19], bp[18]);
    else passed++;
  endtask

  task automatic test_async_reset();
    clr_mon();
    start_wch = 4'b1000;
    tick();
    start_wch = '0;
    tick();
    tick();
    start_wch = 4'b0001;
    tick();
    start_wch = '0;
    wait_beats(4, "arst_pre");
    total++;
    if (pending !== 4'b0001 || ob.out_valid !== 1'b1)
      $display("FAIL arst_pre_state: pend=%b v=%b want 0001 1", pending, ob.out_valid);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (ob.out_valid !== 1'b0 || busy !== 1'b0 || pending !== 4'b0 ||
        ip_select !== 3'b0 || ob.out_index !== 3'b0 || ob.out_neuron !== 2'b0 ||
        ob.del_w_plus !== 24'b0 || ob.out_last !== 1'b0 || done !== 1'b0)
      $display("FAIL arst_clear: v=%b busy=%b pend=%b ip=%0d idx=%0d n=%0d p=%0d",
               ob.out_valid, busy, pending, ip_select, ob.out_index,
               ob.out_neuron, ob.del_w_plus);
    else passed++;
    tick();
    rst = 1'b0;
    tick();
    clr_mon();
    start_wch = 4'b0001;
    tick();
    start_wch = '0;
    wait_done(1, "arst_after");
    total++;
    if (bn.size() !== 8 || bn[0] !== 0 || bp[3] !== 24'hABCDEF || bm[3] !== 203 ||
        bp[5] !== 105)
      $display("FAIL arst_lut_kept: cnt=%0d n=%0d p3=%0h m3=%0d p5=%0d want 8 0 abcdef 203 105",
               bn.size(), bn[0], bp[3], bm[3], bp[5]);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < M; i++) count[CW*i +: CW] = CW'(i);
    ob.out_ready = 1'b1;
    test_reset();
    load_luts();
    test_single_sweep();
    test_round_robin();
    test_stall();
    test_resweep();
    test_lut_busy();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
